cache_fault_sequencer: RTL and testbench

- Controller for the 4-way cache tag store (one tag RAM per way, 512 sets, 13-bit tags).
- Tracks tree pseudo-LRU and dirty state per set, and picks the victim way on a hard fault.
- Sequences the optional dirty writeback and the line fill through a memory request handshake, then issues the tag write.
- Stalls upstream access (busy) for the whole fault service.

---
 rtl/cache_fault_sequencer_if.sv | 50 +++++
 rtl/cache_fault_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_cache_fault_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fault_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_fault_sequencer_if
// Purpose  : Bundles the tag-store lookup, tag-store control and memory
//            request signals shared by the fault sequencer and its peers.
// Ports    : master - sequencer side (drives way_index, tag_write, busy,
//                     mem_req_*), slave - tag store / memory / upstream side.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_fault_sequencer_if #(
    parameter int SET_W = 9,
    parameter int TAG_W = 13
);
    // lookup results from the tag store
    logic                     lookup_valid;
    logic                     lookup_is_write;
    logic [SET_W-1:0]         lookup_set;
    logic [TAG_W-1:0]         lookup_tag;
    logic [1:0]               hit_way;
    logic                     any_fault;
    logic                     hard_fault;
    logic [TAG_W-1:0]         victim_tag;
    // tag store control
    logic [1:0]               way_index;
    logic                     tag_write;
    logic                     busy;
    // memory request handshake
    logic                     mem_req_valid;
    logic                     mem_req_ready;
    logic                     mem_req_is_wb;
    logic [TAG_W+SET_W-1:0]   mem_req_addr;
    logic                     fill_done;

    modport master (
        input  lookup_valid, lookup_is_write, lookup_set, lookup_tag,
        input  hit_way, any_fault, hard_fault, victim_tag,
        output way_index, tag_write, busy,
        output mem_req_valid, mem_req_is_wb, mem_req_addr,
        input  mem_req_ready, fill_done
    );

    modport slave (
        output lookup_valid, lookup_is_write, lookup_set, lookup_tag,
        output hit_way, any_fault, hard_fault, victim_tag,
        input  way_index, tag_write, busy,
        input  mem_req_valid, mem_req_is_wb, mem_req_addr,
        output mem_req_ready, fill_done
    );
endinterface
`default_nettype wire

// File: rtl/cache_fault_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cache_fault_sequencer
// Purpose  : Controller for a 4-way cache tag store. Keeps tree pseudo-LRU
//            and dirty bits per set, selects a victim on a hard fault,
//            sequences optional writeback + line fill over a memory request
//            handshake and finally pulses the tag RAM write.
// Ports    : main_clk  - clock
//            main_rst  - asynchronous active-high reset
//            bus       - cache_fault_sequencer_if.master (lookup inputs,
//                        way_index/tag_write/busy, memory request channel)
// Revision : 1.0 - initial release
// ============================================================================
module cache_fault_sequencer #(
    parameter int SETS  = 512,   // must equal 2**SET_W
    parameter int SET_W = 9,
    parameter int TAG_W = 13
) (
    input  logic                     main_clk,
    input  logic                     main_rst,
    cache_fault_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        VSEL      = 3'd1,
        VREAD     = 3'd2,
        WB_REQ    = 3'd3,
        WB_WAIT   = 3'd4,
        FILL_REQ  = 3'd5,
        FILL_WAIT = 3'd6,
        TAGWR     = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Tree PLRU helpers. b0 selects the half, b1/b2 the way inside it.
    // ------------------------------------------------------------------
    function automatic logic [1:0] plru_victim(input logic [2:0] b);
        if (b[0]) return b[2] ? 2'd3 : 2'd2;
        else      return b[1] ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
        logic [2:0] r;
        r = b;
        if (!w[1]) begin
            r[0] = 1'b1;
            r[1] = (w == 2'd0);
        end else begin
            r[0] = 1'b0;
            r[2] = (w == 2'd2);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [SET_W-1:0]   set_q,   set_d;
    logic [TAG_W-1:0]   tag_q,   tag_d;
    logic               wr_q,    wr_d;
    logic [1:0]         way_q,   way_d;
    logic [TAG_W-1:0]   vtag_q,  vtag_d;

    logic [2:0]         plru_q  [SETS];
    logic [3:0]         dirty_q [SETS];

    // single write port into each per-set array; the FSM never needs two
    // updates of the same array in one cycle
    logic               plru_we;
    logic [SET_W-1:0]   plru_set;
    logic [2:0]         plru_wdata;
    logic               dirty_we;
    logic [SET_W-1:0]   dirty_set;
    logic [1:0]         dirty_way;
    logic               dirty_bit;

    // ------------------------------------------------------------------
    // Next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        tag_d      = tag_q;
        wr_d       = wr_q;
        way_d      = way_q;
        vtag_d     = vtag_q;
        plru_we    = 1'b0;
        plru_set   = '0;
        plru_wdata = '0;
        dirty_we   = 1'b0;
        dirty_set  = '0;
        dirty_way  = '0;
        dirty_bit  = 1'b0;

        bus.way_index     = way_q;
        bus.tag_write     = 1'b0;
        bus.busy          = (state_q != IDLE);
        bus.mem_req_valid = 1'b0;
        bus.mem_req_is_wb = 1'b0;
        bus.mem_req_addr  = '0;

        case (state_q)
            IDLE: begin
                if (bus.lookup_valid) begin
                    if (!bus.any_fault) begin
                        plru_we    = 1'b1;
                        plru_set   = bus.lookup_set;
                        plru_wdata = plru_touch(plru_q[bus.lookup_set], bus.hit_way);
                        if (bus.lookup_is_write) begin
                            dirty_we  = 1'b1;
                            dirty_set = bus.lookup_set;
                            dirty_way = bus.hit_way;
                            dirty_bit = 1'b1;
                        end
                        way_d = bus.hit_way;
                    end else if (bus.hard_fault) begin
                        set_d   = bus.lookup_set;
                        tag_d   = bus.lookup_tag;
                        wr_d    = bus.lookup_is_write;
                        way_d   = plru_victim(plru_q[bus.lookup_set]);
                        state_d = VSEL;
                    end
                end
            end
            // tag store registers way_index; its victim_tag is valid a cycle later
            VSEL: state_d = VREAD;
            VREAD: begin
                vtag_d  = bus.victim_tag;
                state_d = dirty_q[set_q][way_q] ? WB_REQ : FILL_REQ;
            end
            WB_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_is_wb = 1'b1;
                bus.mem_req_addr  = {vtag_q, set_q};
                if (bus.mem_req_ready) state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (bus.fill_done) begin
                    dirty_we  = 1'b1;
                    dirty_set = set_q;
                    dirty_way = way_q;
                    dirty_bit = 1'b0;
                    state_d   = FILL_REQ;
                end
            end
            FILL_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = {tag_q, set_q};
                if (bus.mem_req_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (bus.fill_done) state_d = TAGWR;
            end
            TAGWR: begin
                bus.tag_write = 1'b1;
                plru_we       = 1'b1;
                plru_set      = set_q;
                plru_wdata    = plru_touch(plru_q[set_q], way_q);
                dirty_we      = 1'b1;
                dirty_set     = set_q;
                dirty_way     = way_q;
                dirty_bit     = wr_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            state_q <= IDLE;
            set_q   <= '0;
            tag_q   <= '0;
            wr_q    <= 1'b0;
            way_q   <= 2'd0;
            vtag_q  <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            tag_q   <= tag_d;
            wr_q    <= wr_d;
            way_q   <= way_d;
            vtag_q  <= vtag_d;
        end
    end

    always_ff @(posedge main_clk or posedge main_rst) begin
        if (main_rst) begin
            for (int i = 0; i < SETS; i++) begin
                plru_q[i]  <= 3'b000;
                dirty_q[i] <= 4'b0000;
            end
        end else begin
            if (plru_we)  plru_q[plru_set]              <= plru_wdata;
            if (dirty_we) dirty_q[dirty_set][dirty_way] <= dirty_bit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_fault_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fault_sequencer
// Purpose  : Directed self-checking bench for cache_fault_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fault_sequencer;
    localparam int SET_W = 9;
    localparam int TAG_W = 13;

    logic main_clk = 1'b0;
    logic main_rst;

    cache_fault_sequencer_if #(.SET_W(SET_W), .TAG_W(TAG_W)) bus ();

    cache_fault_sequencer #(.SETS(512), .SET_W(SET_W), .TAG_W(TAG_W)) dut (
        .main_clk (main_clk),
        .main_rst (main_rst),
        .bus      (bus.master)
    );

    always #5 main_clk = ~main_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int base;

    always @(posedge main_clk)
        if (bus.mem_req_valid && bus.mem_req_ready) acc_cnt <= acc_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic idle_in();
        bus.lookup_valid    = 1'b0;
        bus.lookup_is_write = 1'b0;
        bus.lookup_set      = '0;
        bus.lookup_tag      = '0;
        bus.hit_way         = 2'd0;
        bus.any_fault       = 1'b0;
        bus.hard_fault      = 1'b0;
        bus.victim_tag      = '0;
        bus.mem_req_ready   = 1'b0;
        bus.fill_done       = 1'b0;
    endtask

    task automatic clr_lookup();
        bus.lookup_valid = 1'b0;
        bus.any_fault    = 1'b0;
        bus.hard_fault   = 1'b0;
    endtask

    task automatic hit(input logic [SET_W-1:0] s, input logic [1:0] w, input logic wr);
        bus.lookup_valid    = 1'b1;
        bus.lookup_set      = s;
        bus.hit_way         = w;
        bus.lookup_is_write = wr;
        bus.any_fault       = 1'b0;
        bus.hard_fault      = 1'b0;
        tick();
        clr_lookup();
        chk("hit_way_follow", {30'd0, bus.way_index}, {30'd0, w});
    endtask

    // hard fault through VSEL/VREAD; returns positioned in WB_REQ or FILL_REQ
    task automatic start_miss(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                              input logic wr, input logic [TAG_W-1:0] vt,
                              input logic [1:0] exp_way);
        bus.lookup_valid    = 1'b1;
        bus.lookup_set      = s;
        bus.lookup_tag      = t;
        bus.lookup_is_write = wr;
        bus.any_fault       = 1'b1;
        bus.hard_fault      = 1'b1;
        tick();
        clr_lookup();
        chk("miss_victim_way", {30'd0, bus.way_index}, {30'd0, exp_way});
        chk("miss_busy",       {31'd0, bus.busy}, 32'd1);
        chk("miss_no_req_vsel", {31'd0, bus.mem_req_valid}, 32'd0);
        bus.victim_tag = vt;
        tick();
        tick();
    endtask

    task automatic writeback(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] vt);
        chk("wb_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        chk("wb_is_wb", {31'd0, bus.mem_req_is_wb}, 32'd1);
        chk("wb_addr",  {10'd0, bus.mem_req_addr}, {10'd0, vt, s});
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("wb_valid_drop", {31'd0, bus.mem_req_valid}, 32'd0);
        tick();
        bus.fill_done = 1'b1;
        tick();
        bus.fill_done = 1'b0;
    endtask

    task automatic fill(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                        input logic [1:0] w, input bit stress);
        chk("fill_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        chk("fill_is_wb", {31'd0, bus.mem_req_is_wb}, 32'd0);
        chk("fill_addr",  {10'd0, bus.mem_req_addr}, {10'd0, t, s});
        if (stress) begin
            for (int i = 0; i < 10; i++) begin
                bus.fill_done = (i == 2);
                if (i == 4) begin
                    // hard fault on set 5 while busy
                    bus.lookup_valid = 1'b1; bus.lookup_set = 9'd5;
                    bus.any_fault = 1'b1; bus.hard_fault = 1'b1;
                end
                if (i == 5) begin
                    // hit on set 5 way 2 while busy; would retarget its victim
                    bus.lookup_valid = 1'b1; bus.lookup_set = 9'd5;
                    bus.hit_way = 2'd2; bus.lookup_is_write = 1'b1;
                    bus.any_fault = 1'b0; bus.hard_fault = 1'b0;
                end
                tick();
                clr_lookup();
                bus.fill_done = 1'b0;
                chk("stall_valid",  {31'd0, bus.mem_req_valid}, 32'd1);
                chk("stall_addr",   {10'd0, bus.mem_req_addr}, {10'd0, t, s});
                chk("stall_tagwr",  {31'd0, bus.tag_write}, 32'd0);
            end
            // completion coincident with acceptance must not count
            bus.fill_done = 1'b1;
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        bus.fill_done     = 1'b0;
        chk("fill_valid_drop", {31'd0, bus.mem_req_valid}, 32'd0);
        chk("fill_wait_tagwr", {31'd0, bus.tag_write}, 32'd0);
        tick();
        chk("fill_wait_tagwr2", {31'd0, bus.tag_write}, 32'd0);
        bus.fill_done = 1'b1;
        tick();
        bus.fill_done = 1'b0;
        chk("tagwr_pulse", {31'd0, bus.tag_write}, 32'd1);
        chk("tagwr_way",   {30'd0, bus.way_index}, {30'd0, w});
        chk("tagwr_busy",  {31'd0, bus.busy}, 32'd1);
        tick();
        chk("tagwr_single", {31'd0, bus.tag_write}, 32'd0);
        chk("busy_drop",    {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_way"},   {30'd0, bus.way_index}, 32'd0);
        chk({pfx, "_tagwr"}, {31'd0, bus.tag_write}, 32'd0);
        chk({pfx, "_busy"},  {31'd0, bus.busy}, 32'd0);
        chk({pfx, "_valid"}, {31'd0, bus.mem_req_valid}, 32'd0);
        chk({pfx, "_is_wb"}, {31'd0, bus.mem_req_is_wb}, 32'd0);
        chk({pfx, "_addr"},  {10'd0, bus.mem_req_addr}, 32'd0);
    endtask

    initial begin
        idle_in();
        main_rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        main_rst = 1'b0;
        tick();

        // Set 5: hits 0,1,2 leave b0=0,b1=0,b2=1 -> tree victim is way 0
        hit(9'd5, 2'd0, 1'b0);
        hit(9'd5, 2'd1, 1'b0);
        hit(9'd5, 2'd2, 1'b0);
        // soft fault: no state change
        bus.lookup_valid = 1'b1; bus.lookup_set = 9'd5;
        bus.any_fault = 1'b1; bus.hard_fault = 1'b0;
        tick();
        clr_lookup();
        chk("soft_fault_busy", {31'd0, bus.busy}, 32'd0);
        start_miss(9'd5, 13'h0AA, 1'b0, 13'h1FFF, 2'd0);
        fill(9'd5, 13'h0AA, 2'd0, 1'b0);
        // TAGWR touched way 0 -> set 5 bits 3'b111, victim 3

        // Clean miss on a fresh set with a stalled, noisy fill request
        base = acc_cnt;
        start_miss(9'h0F0, 13'h1A3, 1'b1, 13'h0000, 2'd0);
        fill(9'h0F0, 13'h1A3, 2'd0, 1'b1);
        chk("clean_one_req", acc_cnt - base, 32'd1);

        // Set 7: store hit way 2, then hits 3,1 -> b0=1,b2=0 -> victim 2 (dirty)
        hit(9'd7, 2'd2, 1'b1);
        hit(9'd7, 2'd3, 1'b0);
        hit(9'd7, 2'd1, 1'b0);
        base = acc_cnt;
        start_miss(9'd7, 13'h100, 1'b0, 13'h055, 2'd2);
        writeback(9'd7, 13'h055);
        fill(9'd7, 13'h100, 2'd2, 1'b0);
        chk("dirty_two_reqs", acc_cnt - base, 32'd2);
        // retarget way 2; its dirty bit now holds the load's is_write (0)
        hit(9'd7, 2'd3, 1'b0);
        hit(9'd7, 2'd1, 1'b0);
        base = acc_cnt;
        start_miss(9'd7, 13'h101, 1'b1, 13'h100, 2'd2);
        fill(9'd7, 13'h101, 2'd2, 1'b0);
        chk("redo_clean_one_req", acc_cnt - base, 32'd1);

        // Set 5 unaffected by busy-time lookups: victim 3; reset in FILL_WAIT
        start_miss(9'd5, 13'h0BB, 1'b0, 13'h0000, 2'd3);
        chk("rst_case_fill_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk("rst_case_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        main_rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        tick();
        tick();
        main_rst = 1'b0;
        tick();
        start_miss(9'd5, 13'h0CC, 1'b0, 13'h0000, 2'd0);
        fill(9'd5, 13'h0CC, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
